pipeline_ctrl_unit: RTL and testbench
=====================================

# pipeline_ctrl_unit

Central stall/flush sequencer for the 5-stage MIPS pipeline (FETCH, ISS, EX, MEM, WB). It merges four hold sources into one consistent set of per-stage stall and bubble-insert controls: the load-use request from hazard detection, instruction-memory wait, data-memory wait, and the multi-cycle mult/div occupancy of EX. It also applies the EX branch redirect. It tracks multi-cycle holds with a small FSM and a latency counter, and keeps a stall-cycle performance counter.

## Interface
- MD_LATENCY, 32: total cycles a mult/div instruction occupies EX; legal range 2..64.
- CNT_W, 32: width of the stall performance counter.
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-high reset.
- ld_use_hz_i  in  1  load-use hazard: the ISS instruction needs the result of the load in EX.
- br_taken_ex_i  in  1  the EX branch/jump redirects fetch this cycle.
- imem_rdy_i  in  1  instruction fetch data valid this cycle.
- dmem_req_i  in  1  the MEM stage holds a load/store.
- dmem_rdy_i  in  1  data memory completes the MEM access this cycle.
- md_start_i  in  1  the EX stage holds a mult/div instruction.
- stall_fetch_o, stall_iss_o, stall_ex_o, stall_mem_o  out  1 each  hold the PC / pipeline register of that stage.
- flush_iss_o, flush_ex_o, flush_mem_o, flush_wb_o  out  1 each  load a bubble into that stage's input register.
- state_o  out  2  FSM state (RUN=0, DMEM_WAIT=1, MD_BUSY=2).
- stall_cnt_o  out  CNT_W  count of cycles with stall_fetch_o=1.

## Operation
- FSM states: RUN, DMEM_WAIT, MD_BUSY. Encoding 3 is illegal; it recovers to RUN on the next edge with all outputs 0.
- Outputs are Mealy: combinational from state, counter and inputs.
- Sources are evaluated in the RUN state in priority order. The first match decides the outputs:
  1. dmem_req_i & ~dmem_rdy_i: stall fetch/iss/ex/mem and flush_wb. Next state DMEM_WAIT.
  2. md_start_i: stall fetch/iss/ex and flush_mem. Next state MD_BUSY with md_cnt = MD_LATENCY-2.
  3. br_taken_ex_i: flush_iss and no stalls. The EX instruction advances and the wrong-path fetch is dropped.
  4. ld_use_hz_i: stall fetch/iss and flush_ex.
  5. ~imem_rdy_i: stall fetch and flush_iss.
- Branch vs lower sources:
  - When rule 3 fires, rules 4 and 5 are ignored.
  - Under rule 1 or 2, br_taken_ex_i is ignored. EX is held and re-presents the branch later.
- DMEM_WAIT state:
  - While ~dmem_rdy_i: same outputs as rule 1.
  - On dmem_rdy_i: all stall and flush outputs are 0 and the next state is RUN.
  - All other inputs are ignored.
- MD_BUSY state:
  - While md_cnt != 0: outputs as rule 2 and md_cnt decrements.
  - On md_cnt == 0: all stall and flush outputs are 0 and the next state is RUN.
  - dmem_req_i is required to be 0 here (MEM holds a bubble); the bench asserts this.
  - All other inputs are ignored.
- Net mult/div cost: EX is occupied for MD_LATENCY cycles and fetch is stalled for MD_LATENCY-1 cycles.
- stall_cnt_o increments on every edge where stall_fetch_o=1 and wraps from all-ones to 0.

## Timing
- While reset=1: state=RUN, md_cnt=0, stall_cnt_o=0, and all other outputs forced to 0 regardless of inputs.
- Reset asserted mid-DMEM_WAIT or mid-MD_BUSY aborts immediately to RUN with no residual stall.
- No latency on the input-to-output path: each decision applies in the same cycle it is evaluated.
- State and md_cnt update on the rising clk edge.
- A stall and a flush of the same stage are never asserted together.

## Structure
- pipe_ctrl_pkg holds:
  - the state typedef and encodings (RUN, DMEM_WAIT, MD_BUSY);
  - the md_cnt width constant, $clog2(64);
  - the per-stage control bit positions for a packed 8-bit stall/flush vector.
- One sub-module, stall_perf_counter (CNT_W-bit enable counter with async reset), produces stall_cnt_o.

## Test plan
- Reset mid-MD_BUSY (MD_LATENCY=8, deassert after 3 busy cycles) -> state_o=0, all outputs 0, stall_cnt_o=0 on the next cycle.
- md_start_i=1 for one RUN cycle, MD_LATENCY=4 -> stall_fetch_o=1 and flush_mem_o=1 for exactly 3 cycles, then all 0; stall_cnt_o=3.
- dmem_req_i=1 with dmem_rdy_i low for 5 cycles, then high -> stall_mem_o=1 and flush_wb_o=1 for 5 cycles, 0 in the rdy cycle, state returns to 0.
- Same cycle: dmem miss, md_start_i and br_taken_ex_i -> DMEM_WAIT wins; flush_iss_o=0; on release md_start_i is honoured next.
- br_taken_ex_i with ld_use_hz_i and imem_rdy_i=0 in RUN -> flush_iss_o=1, flush_ex_o=0, all stalls 0.
- ld_use_hz_i alone -> stall_fetch_o=stall_iss_o=1, flush_ex_o=1, stall_ex_o=0; MD_LATENCY=2 md_start_i -> exactly 1 stall cycle.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared FSM states, counter width and stall/flush vector layout
// Vector layout: [3:0] stall fetch/iss/ex/mem, [7:4] flush iss/ex/mem/wb
package pipe_ctrl_pkg;
    typedef enum logic [1:0] {RUN = 2'd0, DMEM_WAIT = 2'd1, MD_BUSY = 2'd2} state_t;
    localparam int MD_CNT_W = $clog2(64);
    localparam int STALL_FETCH = 0;
    localparam int STALL_ISS   = 1;
    localparam int STALL_EX    = 2;
    localparam int STALL_MEM   = 3;
    localparam int FLUSH_ISS   = 4;
    localparam int FLUSH_EX    = 5;
    localparam int FLUSH_MEM   = 6;
    localparam int FLUSH_WB    = 7;
    localparam logic [7:0] DMEM_HOLD = 8'((1 << STALL_FETCH) | (1 << STALL_ISS) | (1 << STALL_EX) | (1 << STALL_MEM) | (1 << FLUSH_WB));
    localparam logic [7:0] MD_HOLD   = 8'((1 << STALL_FETCH) | (1 << STALL_ISS) | (1 << STALL_EX) | (1 << FLUSH_MEM));
    localparam logic [7:0] BR_KILL   = 8'(1 << FLUSH_ISS);
    localparam logic [7:0] LD_USE    = 8'((1 << STALL_FETCH) | (1 << STALL_ISS) | (1 << FLUSH_EX));
    localparam logic [7:0] IMEM_WAIT = 8'((1 << STALL_FETCH) | (1 << FLUSH_ISS));
endpackage

// File: rtl/stall_perf_counter.sv
// stall_perf_counter: wrapping enable counter counting stalled fetch cycles
// Ports: clk, reset (async, high), en (count this edge), cnt (running total)
module stall_perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clk or posedge reset)
        if (reset) cnt <= '0;
        else if (en) cnt <= cnt + CNT_W'(1);
endmodule

// File: rtl/pipeline_ctrl_unit.sv
// pipeline_ctrl_unit: merges pipeline hold sources into per-stage stall/flush controls
// Ports: hazard/memory/mult-div/branch status in; stall_*_o and flush_*_o per stage,
// state_o (RUN/DMEM_WAIT/MD_BUSY) and stall_cnt_o (stalled fetch cycles) out
module pipeline_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld_use_hz_i,
    input  logic             br_taken_ex_i,
    input  logic             imem_rdy_i,
    input  logic             dmem_req_i,
    input  logic             dmem_rdy_i,
    input  logic             md_start_i,
    output logic             stall_fetch_o,
    output logic             stall_iss_o,
    output logic             stall_ex_o,
    output logic             stall_mem_o,
    output logic             flush_iss_o,
    output logic             flush_ex_o,
    output logic             flush_mem_o,
    output logic             flush_wb_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o
);
    state_t                state, state_next;
    logic [MD_CNT_W-1:0]   md_cnt, md_next;
    logic [7:0]            ctl_raw, ctl;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state  <= RUN;
            md_cnt <= '0;
        end else begin
            state  <= state_next;
            md_cnt <= md_next;
        end
    always_comb begin
        ctl_raw    = '0;
        state_next = state;
        md_next    = md_cnt;
        case (state)
            RUN: begin
                if (dmem_req_i && !dmem_rdy_i) begin
                    ctl_raw    = DMEM_HOLD;
                    state_next = DMEM_WAIT;
                end else if (md_start_i) begin
                    // The RUN cycle and the release cycle both count toward occupancy
                    ctl_raw    = MD_HOLD;
                    state_next = MD_BUSY;
                    md_next    = MD_CNT_W'(MD_LATENCY - 2);
                end else if (br_taken_ex_i) ctl_raw = BR_KILL;
                else if (ld_use_hz_i) ctl_raw = LD_USE;
                else if (!imem_rdy_i) ctl_raw = IMEM_WAIT;
            end
            DMEM_WAIT: begin
                ctl_raw    = dmem_rdy_i ? '0 : DMEM_HOLD;
                state_next = dmem_rdy_i ? RUN : DMEM_WAIT;
            end
            MD_BUSY: begin
                ctl_raw    = (md_cnt != '0) ? MD_HOLD : '0;
                state_next = (md_cnt != '0) ? MD_BUSY : RUN;
                md_next    = (md_cnt != '0) ? md_cnt - MD_CNT_W'(1) : md_cnt;
            end
            default: begin
                state_next = RUN;
                md_next    = '0;
            end
        endcase
    end
    // Outputs are forced quiet for the whole time reset is held
    assign ctl           = reset ? '0 : ctl_raw;
    assign stall_fetch_o = ctl[STALL_FETCH];
    assign stall_iss_o   = ctl[STALL_ISS];
    assign stall_ex_o    = ctl[STALL_EX];
    assign stall_mem_o   = ctl[STALL_MEM];
    assign flush_iss_o   = ctl[FLUSH_ISS];
    assign flush_ex_o    = ctl[FLUSH_EX];
    assign flush_mem_o   = ctl[FLUSH_MEM];
    assign flush_wb_o    = ctl[FLUSH_WB];
    assign state_o       = state;
    stall_perf_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (stall_fetch_o),
        .cnt   (stall_cnt_o)
    );
endmodule

// File: tb/tb_pipeline_ctrl_unit.sv
// tb_pipeline_ctrl_unit: three DUTs (MD_LATENCY 2/4/8) against a timeline reference model
module tb_pipeline_ctrl_unit;
    localparam logic [7:0] E_DM  = 8'h8F;
    localparam logic [7:0] E_MD  = 8'h47;
    localparam logic [7:0] E_BR  = 8'h10;
    localparam logic [7:0] E_LD  = 8'h23;
    localparam logic [7:0] E_IM  = 8'h11;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ld_use_hz_i = 1'b0, br_taken_ex_i = 1'b0, imem_rdy_i = 1'b1;
    logic dmem_req_i = 1'b0, dmem_rdy_i = 1'b0, md_start_i = 1'b0;
    logic [7:0]  ctl_o [3];
    logic [1:0]  st_o  [3];
    logic [31:0] cnt_o [3];
    int          n_chk = 0;
    int          n_fail = 0;
    int          lat   [3] = '{2, 4, 8};
    int          mode  [3] = '{0, 0, 0};
    int          md_end[3] = '{0, 0, 0};
    logic [31:0] e_cnt [3] = '{0, 0, 0};
    int          cyc = 0;
    always #5 clk = ~clk;
    for (genvar g = 0; g < 3; g++) begin : g_dut
        pipeline_ctrl_unit #(.MD_LATENCY(g == 0 ? 2 : g == 1 ? 4 : 8), .CNT_W(32)) u_dut (
            .clk           (clk),
            .reset         (reset),
            .ld_use_hz_i   (ld_use_hz_i),
            .br_taken_ex_i (br_taken_ex_i),
            .imem_rdy_i    (imem_rdy_i),
            .dmem_req_i    (dmem_req_i),
            .dmem_rdy_i    (dmem_rdy_i),
            .md_start_i    (md_start_i),
            .stall_fetch_o (ctl_o[g][0]),
            .stall_iss_o   (ctl_o[g][1]),
            .stall_ex_o    (ctl_o[g][2]),
            .stall_mem_o   (ctl_o[g][3]),
            .flush_iss_o   (ctl_o[g][4]),
            .flush_ex_o    (ctl_o[g][5]),
            .flush_mem_o   (ctl_o[g][6]),
            .flush_wb_o    (ctl_o[g][7]),
            .state_o       (st_o[g]),
            .stall_cnt_o   (cnt_o[g])
        );
    end
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask
    task automatic step(input logic r, input logic ld, input logic br, input logic im,
                        input logic dq, input logic dr, input logic md);
        logic [7:0] e  [3];
        int         nm [3];
        @(negedge clk);
        reset = r; ld_use_hz_i = ld; br_taken_ex_i = br; imem_rdy_i = im;
        dmem_req_i = dq; dmem_rdy_i = dr; md_start_i = md;
        #1;
        for (int k = 0; k < 3; k++) begin
            e[k] = 8'h00;
            if (r) begin
                mode[k] = 0;
                e_cnt[k] = 0;
            end
            nm[k] = mode[k];
            if (r) nm[k] = 0;
            else if (mode[k] == 1) begin
                if (dr) nm[k] = 0;
                else e[k] = E_DM;
            end else if (mode[k] == 2) begin
                if (cyc == md_end[k]) nm[k] = 0;
                else e[k] = E_MD;
            end else if (dq && !dr) begin
                e[k] = E_DM; nm[k] = 1;
            end else if (md) begin
                // EX busy for lat cycles starting now; last one releases
                e[k] = E_MD; nm[k] = 2; md_end[k] = cyc + lat[k] - 1;
            end else if (br) e[k] = E_BR;
            else if (ld) e[k] = E_LD;
            else if (!im) e[k] = E_IM;
            check($sformatf("ctl%0d", k), 64'(ctl_o[k]), 64'(e[k]));
            check($sformatf("state%0d", k), 64'(st_o[k]), 64'(mode[k]));
            check($sformatf("cnt%0d", k), 64'(cnt_o[k]), 64'(e_cnt[k]));
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            mode[k] = nm[k];
            if (e[k][0]) e_cnt[k] = e_cnt[k] + 32'd1;
        end
        cyc++;
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 1, 0, 0, 0);
    endtask
    initial begin
        step(1, 1, 1, 0, 1, 0, 1);
        step(1, 0, 0, 1, 0, 0, 0);
        idle(2);
        step(0, 1, 0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 1);
        idle(4);
        #1 check("md4_cnt", 64'(cnt_o[1]), 64'd3);
        check("md2_cnt", 64'(cnt_o[0]), 64'd1);
        step(1, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 1, 1, 1, 0);
        idle(1);
        step(1, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 1, 0, 1);
        step(0, 1, 1, 0, 1, 1, 1);
        step(0, 0, 0, 1, 0, 0, 1);
        idle(10);
        step(1, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 1);
        idle(3);
        step(1, 0, 0, 1, 0, 0, 0);
        idle(2);
        for (int i = 0; i < 3000; i++) begin
            logic any_md;
            any_md = (mode[0] == 2) || (mode[1] == 2) || (mode[2] == 2);
            step($urandom_range(0, 99) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 3) != 0, any_md ? 1'b0 : $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
